// File: rtl/output_display_driver_pkg.sv
// Shared constants for the display driver: FSM encodings, segment patterns,
// digit-select codes and the double-dabble step used by the converter.
package output_display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low one-hot digit selects
  localparam logic [2:0] DIG_ONES     = 3'b110;
  localparam logic [2:0] DIG_TENS     = 3'b101;
  localparam logic [2:0] DIG_HUNDREDS = 3'b011;
  localparam logic [2:0] DIG_NONE     = 3'b111;

  localparam int SHIFT_W = 20;  // {hundreds, tens, ones, binary}

  // One double-dabble iteration: add 3 to any BCD nibble >= 5, then shift left.
  function automatic logic [SHIFT_W-1:0] dabble_step(input logic [SHIFT_W-1:0] s);
    logic [SHIFT_W-1:0] adj;
    adj = s;
    if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
    if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
    if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
    return {adj[SHIFT_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/output_display_driver_if.sv
// Debug view of the display driver's internal state, for checkers and benches.
interface output_display_driver_if;
  import output_display_driver_pkg::*;

  state_t      state;
  logic [7:0]  last_value;
  logic [2:0]  bit_cnt;
  logic [1:0]  digit_idx;

  modport master  (output state, output last_value, output bit_cnt, output digit_idx);
  modport monitor (input  state, input  last_value, input  bit_cnt, input  digit_idx);
endinterface

// File: rtl/seven_segment_decoder.sv
// BCD nibble to active-low seven-segment pattern; blank or non-decimal
// nibbles turn every segment off.
module seven_segment_decoder
  import output_display_driver_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg_bar
);

  always_comb begin
    seg_bar = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg_bar = SEG_0;
        4'd1:    seg_bar = SEG_1;
        4'd2:    seg_bar = SEG_2;
        4'd3:    seg_bar = SEG_3;
        4'd4:    seg_bar = SEG_4;
        4'd5:    seg_bar = SEG_5;
        4'd6:    seg_bar = SEG_6;
        4'd7:    seg_bar = SEG_7;
        4'd8:    seg_bar = SEG_8;
        4'd9:    seg_bar = SEG_9;
        default: seg_bar = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/output_display_driver.sv
// Byte-to-BCD converter (serial double dabble) feeding a multiplexed
// three-digit seven-segment display with optional leading-zero blanking.
module output_display_driver
  import output_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [7:0]  display_input,
  output logic [6:0]  seg_bar,
  output logic [2:0]  digit_enable_bar,
  output logic [11:0] bcd_value,
  output logic        busy,
  output_display_driver_if.master dbg
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  state_t              state, state_next;
  logic [7:0]          last_value;
  logic [SHIFT_W-1:0]  shift_reg;
  logic [2:0]          bit_cnt;
  logic                capture, shifting, load;

  logic [CNT_W-1:0]    refresh_cnt;
  logic [1:0]          digit_idx;
  logic [3:0]          sel_nibble;
  logic                sel_blank;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (CLR) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (display_input != last_value) state_next = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == 3'd7)             state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    capture  = 1'b0;
    shifting = 1'b0;
    load     = 1'b0;
    case (state)
      ST_IDLE:  capture  = (display_input != last_value);
      ST_SHIFT: shifting = 1'b1;
      ST_DONE:  load     = 1'b1;
      default:  ;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Conversion datapath; bcd_value only ever takes a finished result.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      last_value <= 8'h00;
      shift_reg  <= '0;
      bit_cnt    <= 3'd0;
      bcd_value  <= 12'h000;
    end else begin
      if (capture) begin
        last_value <= display_input;
        shift_reg  <= {12'h000, display_input};
        bit_cnt    <= 3'd0;
      end else if (shifting) begin
        shift_reg  <= dabble_step(shift_reg);
        bit_cnt    <= bit_cnt + 3'd1;
      end
      if (load) bcd_value <= shift_reg[19:8];
    end
  end

  // Digit scan: each digit is held for REFRESH_DIV cycles.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    digit_enable_bar = DIG_NONE;
    sel_nibble       = 4'd0;
    sel_blank        = 1'b1;
    case (digit_idx)
      2'd0: begin
        digit_enable_bar = DIG_ONES;
        sel_nibble       = bcd_value[3:0];
        sel_blank        = 1'b0;
      end
      2'd1: begin
        digit_enable_bar = DIG_TENS;
        sel_nibble       = bcd_value[7:4];
        sel_blank        = BLANK_LZ && (bcd_value[11:4] == 8'h00);
      end
      2'd2: begin
        digit_enable_bar = DIG_HUNDREDS;
        sel_nibble       = bcd_value[11:8];
        sel_blank        = BLANK_LZ && (bcd_value[11:8] == 4'h0);
      end
      default: ;
    endcase
  end

  seven_segment_decoder u_decoder (
    .nibble  (sel_nibble),
    .blank   (sel_blank),
    .seg_bar (seg_bar)
  );

  assign dbg.state      = state;
  assign dbg.last_value = last_value;
  assign dbg.bit_cnt    = bit_cnt;
  assign dbg.digit_idx  = digit_idx;

endmodule

// File: tb/tb_output_display_driver.sv
// Bench for output_display_driver: two instances (blanking on / off) share
// stimulus; converted values are scoreboarded against a decimal model.
module tb_output_display_driver;
  import output_display_driver_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  din;
  logic [6:0]  seg_a, seg_b;
  logic [2:0]  den_a, den_b;
  logic [11:0] bcd_a, bcd_b;
  logic        busy_a, busy_b;

  int cmp_count  = 0;
  int fail_count = 0;
  logic [11:0] exp_q[$];

  output_display_driver_if dbg_a ();
  output_display_driver_if dbg_b ();

  output_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .CLK(clk), .CLR(clr), .display_input(din), .seg_bar(seg_a),
    .digit_enable_bar(den_a), .bcd_value(bcd_a), .busy(busy_a), .dbg(dbg_a)
  );

  output_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .CLK(clk), .CLR(clr), .display_input(din), .seg_bar(seg_b),
    .digit_enable_bar(den_b), .bcd_value(bcd_b), .busy(busy_b), .dbg(dbg_b)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int h, t, o;
    h = int'(v) / 100;
    t = (int'(v) / 10) % 10;
    o = int'(v) % 10;
    return {4'(h), 4'(t), 4'(o)};
  endfunction

  function automatic logic [6:0] seg_model(input logic [3:0] n, input bit blank);
    if (blank) return 7'h7F;
    case (n)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [2:0] digit_code(input int idx);
    case (idx)
      0: return 3'b110;
      1: return 3'b101;
      2: return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Drive a new value at a negedge; edge k captures, busy is high after
  // edges k..k+8 and the result appears after edge k+9.
  task automatic run_conversion(input logic [7:0] v, input string name);
    logic [11:0] exp;
    exp_q.push_back(to_bcd(v));
    din = v;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cmp_count++;
      if (busy_a !== 1'b1) begin
        fail_count++;
        $display("FAIL %s_busy cycle %0d: got %b expected 1", name, i, busy_a);
      end
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    cmp_count++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      fail_count++;
      $display("FAIL %s_busy_end: got %b/%b expected 0/0", name, busy_a, busy_b);
    end
    cmp_count++;
    if (bcd_a !== exp || bcd_b !== exp) begin
      fail_count++;
      $display("FAIL %s_bcd: got %h/%h expected %h", name, bcd_a, bcd_b, exp);
    end
  endtask

  task automatic get_seg(input int idx, output logic [6:0] sa, output logic [6:0] sb,
                         output bit ok);
    ok = 1'b0;
    sa = 'x;
    sb = 'x;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (den_a === digit_code(idx)) begin
        sa = seg_a;
        sb = seg_b;
        ok = (den_b === den_a);
        return;
      end
    end
  endtask

  task automatic check_display(input logic [11:0] b, input string name);
    logic [6:0] sa, sb, ea, eb;
    logic [3:0] nib;
    bit ok, blank_a;
    for (int idx = 0; idx < 3; idx++) begin
      get_seg(idx, sa, sb, ok);
      nib     = (idx == 0) ? b[3:0] : (idx == 1) ? b[7:4] : b[11:8];
      blank_a = (idx == 2) ? (b[11:8] == 4'h0) : (idx == 1) ? (b[11:4] == 8'h00) : 1'b0;
      ea = seg_model(nib, blank_a);
      eb = seg_model(nib, 1'b0);
      cmp_count++;
      if (!ok) begin
        fail_count++;
        $display("FAIL %s_digit%0d_select: timed out, got %b/%b expected %b",
                 name, idx, den_a, den_b, digit_code(idx));
      end else if (sa !== ea || sb !== eb) begin
        fail_count++;
        $display("FAIL %s_digit%0d_seg: got %h/%h expected %h/%h", name, idx, sa, sb, ea, eb);
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    din = 8'h00;
    repeat (2) @(negedge clk);
    cmp_count++;
    if (bcd_a !== 12'h000 || busy_a !== 1'b0 || bcd_b !== 12'h000) begin
      fail_count++;
      $display("FAIL reset_regs: got bcd=%h busy=%b expected bcd=000 busy=0", bcd_a, busy_a);
    end
    cmp_count++;
    if (seg_a !== 7'h40 || den_a !== 3'b110) begin
      fail_count++;
      $display("FAIL reset_display: got seg=%h den=%b expected seg=40 den=110", seg_a, den_a);
    end
    cmp_count++;
    if (dbg_a.state !== ST_IDLE || dbg_a.last_value !== 8'h00 || dbg_a.digit_idx !== 2'd0) begin
      fail_count++;
      $display("FAIL reset_state: got st=%0d lv=%h idx=%0d expected 0/00/0",
               dbg_a.state, dbg_a.last_value, dbg_a.digit_idx);
    end
    clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmp_count++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
        fail_count++;
        $display("FAIL reset_no_conv cycle %0d: got busy=%b expected 0", i, busy_a);
      end
    end
  endtask

  task automatic test_conversions();
    run_conversion(8'h32, "conv_32");
    check_display(12'h050, "disp_050");
    run_conversion(8'hFF, "conv_ff");
    check_display(12'h255, "disp_255");
    run_conversion(8'hD8, "conv_d8");
    check_display(12'h216, "disp_216");
  endtask

  task automatic test_blanking();
    run_conversion(8'h05, "conv_05");
    check_display(12'h005, "disp_005");
    run_conversion(8'h5A, "conv_5a");
    check_display(12'h090, "disp_090");
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int n = 0; n < 4; n++) begin
      v = 8'($urandom_range(1, 255));
      if (v == dbg_a.last_value) v = v ^ 8'h01;
      run_conversion(v, "conv_rand");
    end
  endtask

  task automatic test_refresh();
    clr = 1'b1;
    din = 8'h00;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      cmp_count++;
      if (den_a !== digit_code((i / 4) % 3) || den_b !== den_a) begin
        fail_count++;
        $display("FAIL refresh cycle %0d: got %b/%b expected %b",
                 i, den_a, den_b, digit_code((i / 4) % 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    exp_q.push_back(to_bcd(8'h32));
    exp_q.push_back(to_bcd(8'hD8));
    din = 8'h32;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cmp_count++;
      if (busy_a !== 1'b1) begin
        fail_count++;
        $display("FAIL b2b_busy1 cycle %0d: got %b expected 1", i, busy_a);
      end
      if (i == 3) din = 8'hD8;
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    cmp_count++;
    if (bcd_a !== exp || busy_a !== 1'b0) begin
      fail_count++;
      $display("FAIL b2b_first: got bcd=%h busy=%b expected bcd=%h busy=0", bcd_a, busy_a, exp);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cmp_count++;
      if (busy_a !== 1'b1) begin
        fail_count++;
        $display("FAIL b2b_busy2 cycle %0d: got %b expected 1", i, busy_a);
      end
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    cmp_count++;
    if (bcd_a !== exp || bcd_b !== exp || busy_a !== 1'b0) begin
      fail_count++;
      $display("FAIL b2b_second: got bcd=%h busy=%b expected bcd=%h busy=0", bcd_a, busy_a, exp);
    end
  endtask

  task automatic test_clr_abort();
    logic [11:0] exp;
    clr = 1'b1;
    din = 8'h00;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    din = 8'hD8;
    repeat (4) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    cmp_count++;
    if (busy_a !== 1'b0 || bcd_a !== 12'h000 || bcd_b !== 12'h000) begin
      fail_count++;
      $display("FAIL abort: got busy=%b bcd=%h expected busy=0 bcd=000", busy_a, bcd_a);
    end
    clr = 1'b0;
    exp_q.push_back(to_bcd(8'hD8));
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cmp_count++;
      if (busy_a !== 1'b1) begin
        fail_count++;
        $display("FAIL abort_restart_busy cycle %0d: got %b expected 1", i, busy_a);
      end
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    cmp_count++;
    if (bcd_a !== exp || busy_a !== 1'b0) begin
      fail_count++;
      $display("FAIL abort_restart_bcd: got bcd=%h busy=%b expected bcd=%h busy=0",
               bcd_a, busy_a, exp);
    end
  endtask

  initial begin
    clr = 1'b1;
    din = 8'h00;
    test_reset();
    test_conversions();
    test_blanking();
    test_random();
    test_refresh();
    test_back_to_back();
    test_clr_abort();
    cmp_count++;
    if (exp_q.size() != 0) begin
      fail_count++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $finish;
  end

endmodule
